// File: rtl/running_max_if.sv
// running_max_if: sample stream in, frame result out.
//   in_valid/in_data/in_last : upstream sample and end-of-frame marker
//   in_ready                 : block can take a sample this cycle
//   out_valid/out_max/out_count : completed-frame result
//   out_ready                : downstream takes the result this cycle
// master = stream source / result sink, slave = running_max block.
interface running_max_if #(
  parameter int unsigned W = 4
);
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_last;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_max;
  logic [3:0]   out_count;
  logic         out_ready;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max, out_count
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max, out_count
  );
endinterface

// File: rtl/running_max.sv
// running_max: tracks the unsigned maximum and sample count (saturating
// at 15) of each frame, then holds the result until downstream takes it.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : running_max_if.slave (sample input + frame result output)
module running_max #(
  parameter int unsigned W = 4
) (
  input logic         clk,
  input logic         rst,
  running_max_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [W-1:0]     max_q;
  logic [CNT_W-1:0] cnt_q;
  logic             accept;

  // Ready is a pure decode of state so it never depends on in_valid.
  assign bus.in_ready  = (state_q != S_DONE);
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.out_max   = max_q;
  assign bus.out_count = cnt_q;

  assign accept = bus.in_valid && (state_q != S_DONE);

  // Frame state, running maximum and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_EMPTY;
      max_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            // First sample always seeds the maximum, whatever its value.
            max_q   <= bus.in_data;
            cnt_q   <= CNT_W'(1);
            state_q <= bus.in_last ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (accept) begin
            // Strict compare: a tie keeps the earlier value.
            if (bus.in_data > max_q) begin
              max_q <= bus.in_data;
            end
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
            state_q <= bus.in_last ? S_DONE : S_ACCUM;
          end
        end
        S_DONE: begin
          // max_q is left alone so out_max persists until the next frame starts.
          if (bus.out_ready) begin
            cnt_q   <= '0;
            state_q <= S_EMPTY;
          end
        end
        default: begin
          state_q <= S_EMPTY;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_running_max.sv
// tb_running_max: directed table, hand-written corner sequences and a
// randomized run against a frame-level reference model for running_max.
module tb_running_max;

  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  running_max_if #(.W(W)) bus ();

  running_max #(.W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, clock once, settle just after the edge.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d,
                      input logic l, input logic o);
    rst          = r;
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.out_ready = o;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic rdy, input logic ov,
                            input int mx, input int cnt);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'(rdy));
    chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
    chk({tag, ".out_max"},   32'(bus.out_max),   32'(mx));
    chk({tag, ".out_count"}, 32'(bus.out_count), 32'(cnt));
  endtask

  typedef struct {
    logic         v;
    logic [W-1:0] d;
    logic         l;
    logic         o;
    logic         e_rdy;
    logic         e_ov;
    logic [W-1:0] e_max;
    logic [3:0]   e_cnt;
  } vec_t;

  vec_t tbl[15];

  // Reference model state for the random run.
  int   q[$];
  bit   hold;
  int   res_max;
  int   res_cnt;

  function automatic int qmax();
    int m = 0;
    foreach (q[i]) if (q[i] > m) m = q[i];
    return m;
  endfunction

  function automatic int sat15(input int n);
    return (n > 15) ? 15 : n;
  endfunction

  initial begin
    int tgt, frames, cyc;
    logic v, l, o;
    logic [W-1:0] d;
    int e_max, e_cnt;

    // Frames 3,9,5 / 0 / 7,7 / gap-split 2,1 with ignored inputs around handshakes.
    tbl[0]  = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd3, 4'd1};
    tbl[1]  = '{1'b1, 4'd9, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd2};
    tbl[2]  = '{1'b1, 4'd5, 1'b1, 1'b1, 1'b0, 1'b1, 4'd9, 4'd3};
    tbl[3]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 4'd0};
    tbl[4]  = '{1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd1};
    tbl[5]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0};
    tbl[6]  = '{1'b1, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 4'd7, 4'd1};
    tbl[7]  = '{1'b1, 4'd7, 1'b1, 1'b0, 1'b0, 1'b1, 4'd7, 4'd2};
    tbl[8]  = '{1'b1, 4'd3, 1'b0, 1'b1, 1'b1, 1'b0, 4'd7, 4'd0};
    tbl[9]  = '{1'b0, 4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 4'd7, 4'd0};
    tbl[10] = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1};
    tbl[11] = '{1'b0, 4'd9, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, 4'd1};
    tbl[12] = '{1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2};
    tbl[13] = '{1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2};
    tbl[14] = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd2, 4'd0};

    // Reset state.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 4'd13, 1'b1, 1'b1);
    expect_out("reset", 1'b1, 1'b0, 0, 0);
    rst = 1'b0;

    // Directed table.
    foreach (tbl[i]) begin
      step(1'b0, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].o);
      expect_out($sformatf("tbl[%0d]", i), tbl[i].e_rdy, tbl[i].e_ov,
                 int'(tbl[i].e_max), int'(tbl[i].e_cnt));
    end

    // Result held under back-pressure; in_valid pulses must not be taken.
    step(1'b0, 1'b1, 4'd15, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd2, 1'b1, 1'b0);
    expect_out("hold0", 1'b0, 1'b1, 15, 2);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'(i % 2 == 0), W'($urandom), 1'(i % 2), 1'b0);
      expect_out($sformatf("hold%0d", i + 1), 1'b0, 1'b1, 15, 2);
    end
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    expect_out("hold_rel", 1'b1, 1'b0, 15, 0);

    // Count saturation: 20 ones then 12(last).
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 4'd1, 1'b0, 1'b0);
    expect_out("sat_acc", 1'b1, 1'b0, 1, 15);
    step(1'b0, 1'b1, 4'd12, 1'b1, 1'b0);
    expect_out("sat_done", 1'b0, 1'b1, 12, 15);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Partial frame discarded by reset, which beats a same-cycle last accept.
    step(1'b0, 1'b1, 4'd4, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'd11, 1'b0, 1'b0);
    expect_out("abort_acc", 1'b1, 1'b0, 11, 2);
    step(1'b1, 1'b1, 4'd9, 1'b1, 1'b1);
    expect_out("abort_rst", 1'b1, 1'b0, 0, 0);
    step(1'b0, 1'b1, 4'd6, 1'b1, 1'b0);
    expect_out("abort_new", 1'b0, 1'b1, 6, 1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Randomized frames against the reference model.
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    q.delete();
    hold    = 1'b0;
    res_max = 0;
    res_cnt = 0;
    frames  = 0;
    cyc     = 0;
    tgt     = $urandom_range(1, 20);
    while (frames < 1000 && cyc < 60000) begin
      if (hold) begin
        e_max = res_max;
        e_cnt = res_cnt;
      end else begin
        e_max = (q.size() > 0) ? qmax() : res_max;
        e_cnt = sat15(q.size());
      end
      expect_out("rnd", !hold, hold, e_max, e_cnt);

      v = ($urandom_range(0, 9) < 7);
      d = W'($urandom);
      l = hold ? 1'($urandom_range(0, 1)) : 1'(q.size() + 1 == tgt);
      o = 1'($urandom_range(0, 1));
      step(1'b0, v, d, l, o);
      cyc++;

      if (!hold) begin
        if (v) begin
          q.push_back(int'(d));
          if (l) begin
            res_max = qmax();
            res_cnt = sat15(q.size());
            q.delete();
            hold = 1'b1;
            frames++;
            tgt = $urandom_range(1, 20);
          end
        end
      end else if (o) begin
        hold    = 1'b0;
        res_cnt = 0;
      end
    end
    n_chk++;
    if (frames < 1000) begin
      n_fail++;
      $display("FAIL rnd.budget: got %0d frames, expected 1000 within 60000 cycles", frames);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
